// File: rtl/zion_riscv_isa_lib_add_sub_arbiter.sv
// Round-robin arbiter in front of a shared add/sub datapath with a single
// registered response slot drained through a valid/ready handshake.

module zion_riscv_isa_lib_add_sub_arbiter_chk #(
    parameter int OP_W = 2
) (
    input logic            clk,
    input logic            rst,
    input logic            i_accept,
    input logic [OP_W-1:0] i_op
);

    // add and sub requested together has no defined result
    always @(posedge clk) begin
        if (!rst && i_accept) begin
            assert (!(i_op[0] && i_op[1]));
        end
    end

endmodule

module zion_riscv_isa_lib_add_sub_arbiter #(
    parameter  int RV64      = 0,
    parameter  int NUM_REQ   = 3,
    localparam int CPU_WIDTH = 32 * (RV64 + 1),
    localparam int OP_W      = RV64 + 2,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             iReqVld,
    output logic [NUM_REQ-1:0]             oReqRdy,
    input  logic [NUM_REQ*OP_W-1:0]        iReqOp,
    input  logic [NUM_REQ*CPU_WIDTH-1:0]   iReqS1,
    input  logic [NUM_REQ*CPU_WIDTH-1:0]   iReqS2,
    input  logic [NUM_REQ-1:0]             iReqUnsigned,
    output logic                           oRspVld,
    input  logic                           iRspRdy,
    output logic [ID_W-1:0]                oRspId,
    output logic [CPU_WIDTH-1:0]           oRspRslt,
    output logic                           oRspLessThan
);

    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic                 w_free;
    logic                 w_accept;
    logic [OP_W-1:0]      w_op;
    logic [CPU_WIDTH-1:0] w_s1;
    logic [CPU_WIDTH-1:0] w_s2;
    logic                 w_uns;
    logic                 w_add;
    logic                 w_sub;
    logic                 w_wop;
    logic [CPU_WIDTH-1:0] w_a;
    logic [CPU_WIDTH-1:0] w_b;
    logic [CPU_WIDTH-1:0] w_cin;
    logic [CPU_WIDTH-1:0] w_t;
    logic [CPU_WIDTH-1:0] w_wext;
    logic [CPU_WIDTH-1:0] w_rslt;
    logic                 w_lt;

    // first valid requester at or after the pointer, wrapping
    always_comb begin : p_winner
        int   idx;
        logic found;
        logic hit;
        idx      = 0;
        found    = 1'b0;
        hit      = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            hit = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                hit = hit | (iReqVld[j] & (idx == j));
            end
            hit      = hit & ~found;
            w_winner = hit ? ID_W'(idx) : w_winner;
            found    = found | hit;
        end
    end

    assign w_free    = ~oRspVld | iRspRdy;
    assign w_accept  = w_free & (|iReqVld) & ~rst;
    assign w_ptr_nxt = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : (w_winner + ID_W'(1));

    // one-hot ready and winner payload select
    always_comb begin
        w_op  = '0;
        w_s1  = '0;
        w_s2  = '0;
        w_uns = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            oReqRdy[j] = w_accept & (w_winner == ID_W'(j));
            if (w_winner == ID_W'(j)) begin
                w_op  = iReqOp[j*OP_W +: OP_W];
                w_s1  = iReqS1[j*CPU_WIDTH +: CPU_WIDTH];
                w_s2  = iReqS2[j*CPU_WIDTH +: CPU_WIDTH];
                w_uns = iReqUnsigned[j];
            end else begin
                w_uns = w_uns;
            end
        end
    end

    // shared adder; op bit OP_W-1 is the .W flag only on RV64
    always_comb begin
        w_add = w_op[0];
        w_sub = w_op[1];
        w_wop = (RV64 != 0) ? w_op[OP_W-1] : 1'b0;
        w_a   = (w_add | w_sub) ? w_s1 : '0;
        w_b   = w_sub ? ~w_s2 : (w_add ? w_s2 : '0);
        w_cin = {{(CPU_WIDTH-1){1'b0}}, w_sub};
        w_t   = w_a + w_b + w_cin;
        for (int i = 0; i < CPU_WIDTH; i++) begin
            w_wext[i] = (i < 32) ? w_t[i] : w_t[31];
        end
        w_rslt = w_wop ? w_wext : w_t;
        w_lt   = (w_uns & (w_s1[CPU_WIDTH-1] ^ w_s2[CPU_WIDTH-1])) ?
                 w_s2[CPU_WIDTH-1] : w_t[CPU_WIDTH-1];
    end

    // round-robin pointer advances past each winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // response slot: a new accept replaces a draining response on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oRspVld      <= 1'b0;
            oRspId       <= '0;
            oRspRslt     <= '0;
            oRspLessThan <= 1'b0;
        end else if (w_accept) begin
            oRspVld      <= 1'b1;
            oRspId       <= w_winner;
            oRspRslt     <= w_rslt;
            oRspLessThan <= w_lt;
        end else if (iRspRdy) begin
            oRspVld      <= 1'b0;
        end else begin
            oRspVld      <= oRspVld;
        end
    end

    zion_riscv_isa_lib_add_sub_arbiter_chk #(
        .OP_W (OP_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_op     (w_op)
    );

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_arbiter.sv
// Directed bench: an RV32 and an RV64 instance with three requesters each,
// table-driven vectors plus hand-written multi-cycle sequences.

module tb_zion_riscv_isa_lib_add_sub_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [2:0]  vld32, rdy32, uns32;
    logic [5:0]  op32;
    logic [95:0] s1_32, s2_32;
    logic        rvld32, rrdy32, lt32;
    logic [1:0]  id32;
    logic [31:0] rslt32;

    logic [2:0]   vld64, rdy64, uns64;
    logic [8:0]   op64;
    logic [191:0] s1_64, s2_64;
    logic         rvld64, rrdy64, lt64;
    logic [1:0]   id64;
    logic [63:0]  rslt64;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    zion_riscv_isa_lib_add_sub_arbiter #(.RV64(0), .NUM_REQ(3)) dut32 (
        .clk(clk), .rst(rst), .iReqVld(vld32), .oReqRdy(rdy32), .iReqOp(op32),
        .iReqS1(s1_32), .iReqS2(s2_32), .iReqUnsigned(uns32), .oRspVld(rvld32),
        .iRspRdy(rrdy32), .oRspId(id32), .oRspRslt(rslt32), .oRspLessThan(lt32)
    );

    zion_riscv_isa_lib_add_sub_arbiter #(.RV64(1), .NUM_REQ(3)) dut64 (
        .clk(clk), .rst(rst), .iReqVld(vld64), .oReqRdy(rdy64), .iReqOp(op64),
        .iReqS1(s1_64), .iReqS2(s2_64), .iReqUnsigned(uns64), .oRspVld(rvld64),
        .iRspRdy(rrdy64), .oRspId(id64), .oRspRslt(rslt64), .oRspLessThan(lt64)
    );

    typedef struct {
        logic [2:0]  vld;
        logic [1:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        uns;
        logic [2:0]  e_rdy;
        logic        e_vld;
        logic [1:0]  e_id;
        logic [31:0] e_rslt;
        logic        e_lt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set32(input logic [2:0] v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic u);
        vld32 = v;
        for (int j = 0; j < 3; j++) begin
            op32[j*2 +: 2]   = op;
            s1_32[j*32 +: 32] = a;
            s2_32[j*32 +: 32] = b;
            uns32[j]          = u;
        end
    endtask

    task automatic set64(input logic [2:0] v, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic u);
        vld64 = v;
        for (int j = 0; j < 3; j++) begin
            op64[j*3 +: 3]    = op;
            s1_64[j*64 +: 64] = a;
            s2_64[j*64 +: 64] = b;
            uns64[j]          = u;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // pointer walk: 0 ->2 ->1 ->1 ->2 ->0 ->1 ->0 ->0 ->0
        vecs[0] = '{3'b010, 2'b01, 32'd5,          32'd7, 1'b0, 3'b010, 1'b1, 2'd1, 32'd12,         1'b0};
        vecs[1] = '{3'b001, 2'b10, 32'hFFFF_FFFF,  32'd1, 1'b0, 3'b001, 1'b1, 2'd0, 32'hFFFF_FFFE,  1'b1};
        vecs[2] = '{3'b001, 2'b10, 32'hFFFF_FFFF,  32'd1, 1'b1, 3'b001, 1'b1, 2'd0, 32'hFFFF_FFFE,  1'b0};
        vecs[3] = '{3'b111, 2'b10, 32'd3,          32'd5, 1'b0, 3'b010, 1'b1, 2'd1, 32'hFFFF_FFFE,  1'b1};
        vecs[4] = '{3'b111, 2'b10, 32'd3,          32'd5, 1'b1, 3'b100, 1'b1, 2'd2, 32'hFFFF_FFFE,  1'b1};
        vecs[5] = '{3'b111, 2'b00, 32'd9,          32'd9, 1'b0, 3'b001, 1'b1, 2'd0, 32'd0,          1'b0};
        vecs[6] = '{3'b101, 2'b01, 32'hFFFF_FFFF,  32'd1, 1'b0, 3'b100, 1'b1, 2'd2, 32'd0,          1'b0};
        vecs[7] = '{3'b100, 2'b10, 32'd0,          32'd1, 1'b1, 3'b100, 1'b1, 2'd2, 32'hFFFF_FFFF,  1'b1};
        vecs[8] = '{3'b000, 2'b01, 32'd4,          32'd4, 1'b0, 3'b000, 1'b0, 2'd2, 32'hFFFF_FFFF,  1'b1};

        rst    = 1'b1;
        rrdy32 = 1'b1;
        rrdy64 = 1'b1;
        set32(3'b111, 2'b01, 32'd1, 32'd1, 1'b0);
        set64(3'b000, 3'b001, 64'd0, 64'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy",  64'(rdy32),  64'd0);
        chk("reset_vld",  64'(rvld32), 64'd0);
        chk("reset_rslt", 64'(rslt32), 64'd0);
        chk("reset_id",   64'(id32),   64'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_rdy", 64'(rdy32), 64'd1);
        vld32 = 3'b000;

        for (int i = 0; i < 9; i++) begin
            set32(vecs[i].vld, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].uns);
            #1;
            chk($sformatf("vec%0d_rdy", i), 64'(rdy32), 64'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_vld", i),  64'(rvld32), 64'(vecs[i].e_vld));
            chk($sformatf("vec%0d_id", i),   64'(id32),   64'(vecs[i].e_id));
            chk($sformatf("vec%0d_rslt", i), 64'(rslt32), 64'(vecs[i].e_rslt));
            chk($sformatf("vec%0d_lt", i),   64'(lt32),   64'(vecs[i].e_lt));
        end

        // full round robin from pointer 0
        set32(3'b111, 2'b01, 32'd1, 32'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("rr3_id", 64'(id32), 64'(k % 3));
        end
        vld32 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("rr2_id", 64'(id32), (k % 2 == 0) ? 64'd0 : 64'd2);
        end

        // backpressure holds the slot and blocks all requesters
        rrdy32 = 1'b0;
        set32(3'b111, 2'b10, 32'd1, 32'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy", 64'(rdy32), 64'd0);
            @(posedge clk);
            #1;
            chk("bp_vld",  64'(rvld32), 64'd1);
            chk("bp_id",   64'(id32),   64'd2);
            chk("bp_rslt", 64'(rslt32), 64'd2);
        end
        rrdy32 = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_release_vld",  64'(rvld32), 64'd1);
        chk("bp_release_id",   64'(id32),   64'd0);
        chk("bp_release_rslt", 64'(rslt32), 64'd0);

        // reset while a response is held
        rst = 1'b1;
        #1;
        chk("midrst_vld", 64'(rvld32), 64'd0);
        chk("midrst_rdy", 64'(rdy32),  64'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_vld", 64'(rvld32), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_after_rdy", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        chk("midrst_after_id",  64'(id32),   64'd0);
        chk("midrst_after_vld", 64'(rvld32), 64'd1);
        vld32 = 3'b000;

        // RV64 .W operations
        set64(3'b001, 3'b101, 64'h7FFF_FFFF, 64'd1, 1'b0);
        #1;
        chk("w_add_rdy", 64'(rdy64), 64'd1);
        @(posedge clk);
        #1;
        chk("w_add_rslt", rslt64, 64'hFFFF_FFFF_8000_0000);
        set64(3'b001, 3'b001, 64'h7FFF_FFFF, 64'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("add64_rslt", rslt64, 64'h0000_0000_8000_0000);
        set64(3'b001, 3'b110, 64'd0, 64'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("w_sub_rslt", rslt64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w_sub_lt",   64'(lt64), 64'd1);
        chk("w_sub_id",   64'(id64), 64'd0);
        vld64 = 3'b000;
        @(posedge clk);
        #1;
        chk("rsp64_drain", 64'(rvld64), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/zion_riscv_isa_lib_add_sub_arbiter.md
# zion_riscv_isa_lib_add_sub_arbiter

Round-robin arbiter that lets several requesters share one add/sub datapath in the execute stage. Typical requesters are ALU ADD/SUB, load/store address generation and branch/SLT compare. Each cycle it grants at most one valid request and computes the add, sub or .W result plus the signed/unsigned less-than flag. The outcome goes into a single registered response slot, which downstream consumers drain through a valid/ready handshake.

## Interface
- RV64, 0, 1 = RV64I datapath (64-bit, .W ops legal); 0 = RV32I (32-bit). CPU_WIDTH = 32*(RV64+1); OP_W = RV64+2.
- NUM_REQ, 3, number of requesters, 2..8. ID_W = max(1, $clog2(NUM_REQ)).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- iReqVld  in  NUM_REQ  per-requester request valid.
- oReqRdy  out  NUM_REQ  per-requester accept; at most one bit set.
- iReqOp  in  NUM_REQ*OP_W  slot i at [i*OP_W +: OP_W]. op[0] = add, op[1] = sub, op[2] = .W (RV64 only).
- iReqS1, iReqS2  in  NUM_REQ*CPU_WIDTH  operands, slot i at [i*CPU_WIDTH +: CPU_WIDTH].
- iReqUnsigned  in  NUM_REQ  unsigned compare flag, per requester.
- oRspVld  out  1  response valid.
- iRspRdy  in  1  response consumed.
- oRspId  out  ID_W  index of the requester that produced the response.
- oRspRslt  out  CPU_WIDTH  add/sub result.
- oRspLessThan  out  1  less-than flag.

## Operation
- **Slot free:** `free = ~oRspVld | iRspRdy`.
- **Accept:** `accept = free & |iReqVld & ~rst`.
- **Winner:** the first valid index at or after pointer `ptr`, searching upward and wrapping modulo NUM_REQ.
- **Ready:** `oReqRdy[winner] = accept`; all other bits are 0. oReqRdy is combinational from iReqVld, `ptr`, oRspVld and iRspRdy.
- **Requester hold rule:** a requester holds valid and payload stable until it sees ready. Dropping valid without ready is allowed and has no effect.
- **Pointer update:** on accept, `ptr <= (winner+1) mod NUM_REQ`. Otherwise `ptr` holds.
- **Arithmetic on the winner's payload:**
  - `a = (add|sub) ? s1 : 0`.
  - `b = sub ? ~s2 : (add ? s2 : 0)`.
  - `t = a + b + sub`, truncated to CPU_WIDTH.
  - op = 00 gives result 0.
  - op[0] & op[1] both set is illegal: an immediate assertion fires, the result is undefined, and the handshake still completes normally.
- **.W ops (RV64=1 and op[2]=1):** result = `{{32{t[31]}}, t[31:0]}`. When RV64=0, op bit 2 does not exist.
- **Less-than:** `lt = (unsigned & (s1[MSB]^s2[MSB])) ? s2[MSB] : t[MSB]`, with MSB = CPU_WIDTH-1. It uses the full-width `t` before .W extension and is meaningful only for sub.
- **Response register update:**
  - On accept: load `oRspVld <= 1`, `oRspId <= winner`, `oRspRslt`, `oRspLessThan`.
  - Else, if `iRspRdy`: `oRspVld <= 0`, and data holds its last value.
  - Else: everything holds.
- **No fallthrough:** with the slot free, iRspRdy=1 and a valid request, the old response leaves and the new one loads in the same edge.
- **Reset values:** `ptr` = 0, oRspVld = 0, oRspId = 0, oRspRslt = 0, oRspLessThan = 0. oReqRdy = 0 while rst is high.
- **Reset mid-operation:** any held response is discarded and requests presented during reset are not accepted.

## Timing
- Latency: a request accepted at edge N (ready high in cycle N-1) has its response valid in cycle N, i.e. 1 cycle.
- Throughput: 1 request per cycle while iRspRdy=1.
- Backpressure: with oRspVld=1 and iRspRdy=0:
  - all oReqRdy are 0;
  - the response is stable;
  - `ptr` is frozen.
- Fairness: with all NUM_REQ requesters continuously valid and no stalls, each is granted exactly once every NUM_REQ cycles.
- Single requester: a lone valid requester is granted every free cycle regardless of `ptr`.

## Test plan
- **Reset:** RV64=0, NUM_REQ=3. Assert rst with iReqVld=111 → oReqRdy=000, oRspVld=0, oRspRslt=0. Deassert rst → first grant goes to id 0.
- **Add:** req1 only, op=01, s1=5, s2=7 → oReqRdy=010. Next cycle: oRspVld=1, oRspId=1, oRspRslt=12.
- **Sub compare:** req0 op=10, s1=0xFFFFFFFF, s2=1.
  - unsigned=0 → oRspRslt=0xFFFFFFFE, oRspLessThan=1.
  - same operands, unsigned=1 → oRspLessThan=0.
- **Round-robin:** iReqVld=111 held, iRspRdy=1 → oRspId sequence 0,1,2,0,1,2. With req1 dropped → 0,2,0,2.
- **Backpressure:** iRspRdy=0 for 3 cycles while oRspVld=1 → oReqRdy=000, response unchanged. Then iRspRdy=1 → in the same cycle the next request is accepted and the response is replaced on the following edge with no bubble.
- **RV64 .W ops (RV64=1):**
  - op=101, s1=0x7FFFFFFF, s2=1 → oRspRslt=0xFFFFFFFF80000000.
  - op=001, same operands → oRspRslt=0x0000000080000000.
